// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Shared types and defaults for the PSRAM request arbiter.
//   arb_state_t : arbiter sequencing states
//   chan_t      : requesting channel identifier
//   START_TIMEOUT_DEFAULT / ERR_DATA_DEFAULT : default parameter values
//   MC_NBYTES   : fixed transfer length presented to the controller
// -----------------------------------------------------------------------------
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        BUSY    = 2'd2,
        RESPOND = 2'd3
    } arb_state_t;

    typedef enum logic {
        CH_CPU = 1'b0,
        CH_VIC = 1'b1
    } chan_t;

    localparam int         START_TIMEOUT_DEFAULT = 16;
    localparam logic [7:0] ERR_DATA_DEFAULT      = 8'hFF;
    localparam logic [3:0] MC_NBYTES             = 4'd1;

endpackage

// File: rtl/mem_rr_grant.sv
// -----------------------------------------------------------------------------
// mem_rr_grant
// Combinational two-way grant decision for the arbiter.
//   cpu_req, vic_req : pending requests
//   last_grant       : channel served by the previous transaction
//   grant_valid      : at least one request is pending
//   grant_ch         : winning channel (fixed VIC priority or round-robin on ties)
// -----------------------------------------------------------------------------
module mem_rr_grant
    import mem_pkg::*;
#(
    parameter bit VIC_PRIORITY = 1'b0
) (
    input  logic  cpu_req,
    input  logic  vic_req,
    input  chan_t last_grant,
    output logic  grant_valid,
    output chan_t grant_ch
);

    // Pick the winner; on a tie round-robin hands the grant to the channel not served last.
    always_comb begin
        grant_valid = cpu_req | vic_req;
        grant_ch    = CH_CPU;
        if (cpu_req && vic_req) begin
            if (VIC_PRIORITY) begin
                grant_ch = CH_VIC;
            end else if (last_grant == CH_CPU) begin
                grant_ch = CH_VIC;
            end else begin
                grant_ch = CH_CPU;
            end
        end else if (vic_req) begin
            grant_ch = CH_VIC;
        end else begin
            grant_ch = CH_CPU;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Serialises byte accesses from the CPU (read/write) and VIC (read-only)
// channels onto the PSRAM controller request interface.
//   clk, reset          : clock, asynchronous active-high reset
//   cpu_*               : CPU request channel (req/we/bank/addr/wdata, ack/rdata)
//   vic_*               : VIC read channel (req/bank/addr, ack/rdata)
//   mc_*                : controller interface (ce/write/bank/addr/nbytes/wdata,
//                         rdata/busy)
//   err                 : one-cycle pulse when the controller never started
// All outputs are registered. A request is aborted with ERR_DATA if mc_busy
// does not rise within START_TIMEOUT cycles of mc_ce.
// -----------------------------------------------------------------------------
module mem_arbiter
    import mem_pkg::*;
#(
    parameter bit         VIC_PRIORITY  = 1'b0,
    parameter int         START_TIMEOUT = START_TIMEOUT_DEFAULT,
    parameter logic [7:0] ERR_DATA      = ERR_DATA_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [6:0]  cpu_bank,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic        cpu_ack,
    output logic [7:0]  cpu_rdata,
    input  logic        vic_req,
    input  logic [6:0]  vic_bank,
    input  logic [15:0] vic_addr,
    output logic        vic_ack,
    output logic [7:0]  vic_rdata,
    output logic        mc_ce,
    output logic        mc_write,
    output logic [6:0]  mc_bank,
    output logic [15:0] mc_addr,
    output logic [3:0]  mc_nbytes,
    output logic [7:0]  mc_wdata,
    input  logic [7:0]  mc_rdata,
    input  logic        mc_busy,
    output logic        err
);

    localparam int             TW         = $clog2(START_TIMEOUT) + 1;
    localparam logic [TW-1:0]  TIMER_LAST = TW'(START_TIMEOUT - 1);

    arb_state_t    state_r;
    chan_t         owner_r;
    chan_t         last_grant_r;
    logic [TW-1:0] timer_r;

    logic          grant_valid_s;
    chan_t         grant_ch_s;
    logic          timeout_s;
    logic          done_s;
    logic          finish_s;
    logic [7:0]    resp_data_s;

    mem_rr_grant #(
        .VIC_PRIORITY (VIC_PRIORITY)
    ) u_grant (
        .cpu_req     (cpu_req),
        .vic_req     (vic_req),
        .last_grant  (last_grant_r),
        .grant_valid (grant_valid_s),
        .grant_ch    (grant_ch_s)
    );

    // The controller always sees single-byte transfers.
    assign mc_nbytes = MC_NBYTES;

    // A busy indication in ISSUE wins over a coinciding timeout.
    assign timeout_s = (state_r == ISSUE) && !mc_busy && (timer_r == TIMER_LAST);
    assign done_s    = (state_r == BUSY) && !mc_busy;
    assign finish_s  = timeout_s | done_s;

    // Data handed back to the owner: controller data on completion, abort pattern on timeout.
    always_comb begin
        if (timeout_s) begin
            resp_data_s = ERR_DATA;
        end else begin
            resp_data_s = mc_rdata;
        end
    end

    // Arbiter FSM with all registered outputs; ack/err are single-cycle pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= IDLE;
            owner_r      <= CH_CPU;
            last_grant_r <= CH_CPU;
            timer_r      <= '0;
            mc_ce        <= 1'b0;
            mc_write     <= 1'b0;
            mc_bank      <= 7'd0;
            mc_addr      <= 16'd0;
            mc_wdata     <= 8'd0;
            cpu_ack      <= 1'b0;
            cpu_rdata    <= 8'd0;
            vic_ack      <= 1'b0;
            vic_rdata    <= 8'd0;
            err          <= 1'b0;
        end else begin
            cpu_ack <= 1'b0;
            vic_ack <= 1'b0;
            err     <= timeout_s;

            if (finish_s) begin
                if (owner_r == CH_VIC) begin
                    vic_rdata <= resp_data_s;
                    vic_ack   <= 1'b1;
                end else begin
                    cpu_rdata <= resp_data_s;
                    cpu_ack   <= 1'b1;
                end
            end

            case (state_r)
                IDLE: begin
                    if (grant_valid_s) begin
                        owner_r <= grant_ch_s;
                        mc_ce   <= 1'b1;
                        timer_r <= '0;
                        state_r <= ISSUE;
                        if (grant_ch_s == CH_VIC) begin
                            mc_bank  <= vic_bank;
                            mc_addr  <= vic_addr;
                            mc_wdata <= 8'd0;
                            mc_write <= 1'b0;
                        end else begin
                            mc_bank  <= cpu_bank;
                            mc_addr  <= cpu_addr;
                            mc_wdata <= cpu_wdata;
                            mc_write <= cpu_we;
                        end
                    end
                end
                ISSUE: begin
                    timer_r <= timer_r + TW'(1);
                    if (mc_busy) begin
                        mc_ce   <= 1'b0;
                        state_r <= BUSY;
                    end else if (timeout_s) begin
                        mc_ce   <= 1'b0;
                        state_r <= RESPOND;
                    end
                end
                BUSY: begin
                    if (done_s) begin
                        state_r <= RESPOND;
                    end
                end
                RESPOND: begin
                    last_grant_r <= owner_r;
                    state_r      <= IDLE;
                end
                default: begin
                    mc_ce   <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Two arbiter instances share one clock and reset: index 0 is round-robin,
// index 1 gives VIC fixed priority. A behavioural controller per instance
// raises busy one cycle after seeing mc_ce and drops it bdur cycles later
// with nxt_rd on mc_rdata (or never raises it, for the timeout case).
// Directed vectors come from a table; a random phase on instance 0 checks
// grants and read data against a request-level arbitration model.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;
    import mem_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [1:0]       cpu_req, cpu_we, cpu_ack, vic_req, vic_ack;
    logic [1:0]       mc_ce, mc_write, mc_busy, err;
    logic [1:0][6:0]  cpu_bank, vic_bank, mc_bank;
    logic [1:0][15:0] cpu_addr, vic_addr, mc_addr;
    logic [1:0][7:0]  cpu_wdata, cpu_rdata, vic_rdata, mc_wdata, mc_rdata;
    logic [1:0][3:0]  mc_nbytes;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        mem_arbiter #(
            .VIC_PRIORITY  (g == 1),
            .START_TIMEOUT (16),
            .ERR_DATA      (8'hFF)
        ) dut (
            .clk       (clk),
            .reset     (reset),
            .cpu_req   (cpu_req[g]),
            .cpu_we    (cpu_we[g]),
            .cpu_bank  (cpu_bank[g]),
            .cpu_addr  (cpu_addr[g]),
            .cpu_wdata (cpu_wdata[g]),
            .cpu_ack   (cpu_ack[g]),
            .cpu_rdata (cpu_rdata[g]),
            .vic_req   (vic_req[g]),
            .vic_bank  (vic_bank[g]),
            .vic_addr  (vic_addr[g]),
            .vic_ack   (vic_ack[g]),
            .vic_rdata (vic_rdata[g]),
            .mc_ce     (mc_ce[g]),
            .mc_write  (mc_write[g]),
            .mc_bank   (mc_bank[g]),
            .mc_addr   (mc_addr[g]),
            .mc_nbytes (mc_nbytes[g]),
            .mc_wdata  (mc_wdata[g]),
            .mc_rdata  (mc_rdata[g]),
            .mc_busy   (mc_busy[g]),
            .err       (err[g])
        );
    end

    // Controller model state (written only by the model process except the knobs).
    int         ph[2];
    int         cnt[2];
    int         bdur[2];
    bit         never_busy[2];
    logic [7:0] nxt_rd[2];

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Behavioural PSRAM controller, acting on the falling edge.
    initial begin
        mc_busy  = 2'b00;
        mc_rdata = '0;
        ph       = '{0, 0};
        cnt      = '{0, 0};
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (reset) begin
                    ph[i]      = 0;
                    mc_busy[i] = 1'b0;
                end else begin
                    case (ph[i])
                        0: if (mc_ce[i] && !never_busy[i]) ph[i] = 1;
                        1: begin mc_busy[i] = 1'b1; cnt[i] = bdur[i]; ph[i] = 2; end
                        2: begin
                            if (cnt[i] == 0) begin
                                mc_busy[i]  = 1'b0;
                                mc_rdata[i] = nxt_rd[i];
                                ph[i]       = 0;
                            end else begin
                                cnt[i]--;
                            end
                        end
                        default: ph[i] = 0;
                    endcase
                end
            end
        end
    end

    task automatic wait_ce(input int i);
        int n = 0;
        @(negedge clk);
        while (!mc_ce[i] && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("ce_seen", 32'(mc_ce[i]), 32'd1);
    endtask

    task automatic check_grant(input int i, input bit is_vic, input bit we,
                               input logic [6:0] bank, input logic [15:0] addr,
                               input logic [7:0] wd);
        chk("mc_write", 32'(mc_write[i]), is_vic ? 32'd0 : 32'(we));
        chk("mc_bank", 32'(mc_bank[i]), 32'(bank));
        chk("mc_addr", 32'(mc_addr[i]), 32'(addr));
        chk("mc_nbytes", 32'(mc_nbytes[i]), 32'd1);
        if (!is_vic && we) chk("mc_wdata", 32'(mc_wdata[i]), 32'(wd));
    endtask

    task automatic wait_ack(input int i, input bit is_vic, input logic [7:0] rd, input bit chk_rd);
        int n = 0;
        while (!(cpu_ack[i] || vic_ack[i]) && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("ack_channel", 32'({cpu_ack[i], vic_ack[i]}), is_vic ? 32'd1 : 32'd2);
        if (chk_rd) chk("rdata", is_vic ? 32'(vic_rdata[i]) : 32'(cpu_rdata[i]), 32'(rd));
    endtask

    typedef struct {
        int          inst;
        bit          c, v, we;
        logic [6:0]  cb, vb;
        logic [15:0] ca, va;
        logic [7:0]  wd, rd;
        bit          exp_vic;
    } vec_t;

    vec_t tab[11];

    task automatic run_vec(input vec_t t);
        int i = t.inst;
        @(posedge clk); #1;
        nxt_rd[i]    = t.rd;
        cpu_req[i]   = t.c;   cpu_we[i]   = t.we;  cpu_bank[i] = t.cb;
        cpu_addr[i]  = t.ca;  cpu_wdata[i] = t.wd;
        vic_req[i]   = t.v;   vic_bank[i] = t.vb;  vic_addr[i] = t.va;
        wait_ce(i);
        check_grant(i, t.exp_vic, t.we, t.exp_vic ? t.vb : t.cb, t.exp_vic ? t.va : t.ca, t.wd);
        wait_ack(i, t.exp_vic, t.rd, t.exp_vic || !t.we);
        @(posedge clk); #1;
        cpu_req[i] = 1'b0;
        vic_req[i] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int    n;
        bit    pc, pv, win_vic;
        chan_t last;

        //           inst c  v  we  cb     vb      ca        va        wd     rd     exp_vic
        tab[0]  = '{0, 1, 1, 0, 7'd1,  7'd5,  16'h0200, 16'h0100, 8'h00, 8'h11, 1'b1};
        tab[1]  = '{0, 1, 1, 0, 7'd1,  7'd5,  16'h0200, 16'h0100, 8'h00, 8'h22, 1'b0};
        tab[2]  = '{0, 1, 1, 0, 7'd1,  7'd5,  16'h0200, 16'h0100, 8'h00, 8'h33, 1'b1};
        tab[3]  = '{0, 1, 1, 0, 7'd1,  7'd5,  16'h0200, 16'h0100, 8'h00, 8'h44, 1'b0};
        tab[4]  = '{0, 1, 0, 0, 7'd3,  7'd0,  16'h1234, 16'h0000, 8'h00, 8'hA5, 1'b0};
        tab[5]  = '{0, 1, 0, 1, 7'd7,  7'd0,  16'hBEEF, 16'h0000, 8'h3C, 8'h00, 1'b0};
        tab[6]  = '{0, 0, 1, 0, 7'd0,  7'h40, 16'h0000, 16'hFFFF, 8'h00, 8'h5A, 1'b1};
        tab[7]  = '{1, 1, 1, 1, 7'd2,  7'd6,  16'h0A0A, 16'h0B0B, 8'h77, 8'h61, 1'b1};
        tab[8]  = '{1, 1, 1, 1, 7'd2,  7'd6,  16'h0A0A, 16'h0B0B, 8'h77, 8'h62, 1'b1};
        tab[9]  = '{1, 1, 1, 1, 7'd2,  7'd6,  16'h0A0A, 16'h0B0B, 8'h77, 8'h63, 1'b1};
        tab[10] = '{1, 1, 0, 0, 7'd2,  7'd0,  16'h0C0C, 16'h0000, 8'h00, 8'h64, 1'b0};

        reset = 1'b1;
        cpu_req = '0; cpu_we = '0; cpu_bank = '0; cpu_addr = '0; cpu_wdata = '0;
        vic_req = '0; vic_bank = '0; vic_addr = '0;
        bdur = '{1, 1}; never_busy = '{1'b0, 1'b0}; nxt_rd = '{8'h00, 8'h00};
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("rst_ctrl", 32'({cpu_ack[i], vic_ack[i], mc_ce[i], mc_write[i], err[i]}), 32'd0);
            chk("rst_nbytes", 32'(mc_nbytes[i]), 32'd1);
            chk("rst_data", 32'({cpu_rdata[i], vic_rdata[i], mc_wdata[i]}), 32'd0);
            chk("rst_addr", 32'({mc_bank[i], mc_addr[i]}), 32'd0);
        end
        reset = 1'b0;

        // Directed table: round-robin alternation, single reads/writes, VIC priority.
        for (int k = 0; k < 11; k++) run_vec(tab[k]);

        // Start timeout: controller never goes busy.
        @(posedge clk); #1;
        never_busy[0] = 1'b1;
        cpu_req[0] = 1'b1; cpu_we[0] = 1'b0; cpu_bank[0] = 7'd2; cpu_addr[0] = 16'h0042;
        wait_ce(0);
        n = 0;
        while (mc_ce[0] && n < 40) begin
            n++;
            @(negedge clk);
        end
        chk("timeout_ce_cycles", 32'(n), 32'd16);
        chk("timeout_err_ack", 32'({err[0], cpu_ack[0], vic_ack[0]}), 32'b110);
        chk("timeout_rdata", 32'(cpu_rdata[0]), 32'hFF);
        @(posedge clk); #1;
        cpu_req[0] = 1'b0;
        never_busy[0] = 1'b0;
        @(negedge clk);
        chk("timeout_pulse_end", 32'({err[0], cpu_ack[0]}), 32'd0);
        run_vec(tab[4]);

        // Reset while the controller is busy drops the access.
        @(posedge clk); #1;
        bdur[0] = 6; nxt_rd[0] = 8'h77;
        cpu_req[0] = 1'b1; cpu_we[0] = 1'b1; cpu_wdata[0] = 8'h99;
        cpu_bank[0] = 7'd9; cpu_addr[0] = 16'h5555;
        wait_ce(0);
        n = 0;
        while (mc_ce[0] && n < 10) begin
            @(negedge clk);
            n++;
        end
        #2 reset = 1'b1;
        #1;
        chk("busy_rst_ctrl", 32'({mc_ce[0], mc_write[0], cpu_ack[0], err[0]}), 32'd0);
        chk("busy_rst_addr", 32'({mc_bank[0], mc_addr[0]}), 32'd0);
        chk("busy_rst_data", 32'({cpu_rdata[0], mc_wdata[0]}), 32'd0);
        chk("busy_rst_nbytes", 32'(mc_nbytes[0]), 32'd1);
        cpu_req[0] = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        n = 0;
        repeat (8) begin
            @(negedge clk);
            if (cpu_ack[0] || vic_ack[0] || err[0]) n++;
        end
        chk("busy_rst_no_ack", 32'(n), 32'd0);
        bdur[0] = 1;
        run_vec(tab[4]);

        // Random traffic on the round-robin instance; the loser keeps holding its request.
        last = CH_CPU;
        pc = 1'b0; pv = 1'b0;
        for (int t = 0; t < 60; t++) begin
            @(posedge clk); #1;
            if (!pc && $urandom_range(3) != 0) begin
                pc = 1'b1;
                cpu_we[0] = 1'($urandom); cpu_bank[0] = 7'($urandom);
                cpu_addr[0] = 16'($urandom); cpu_wdata[0] = 8'($urandom);
                cpu_req[0] = 1'b1;
            end
            if (!pv && $urandom_range(3) != 0) begin
                pv = 1'b1;
                vic_bank[0] = 7'($urandom); vic_addr[0] = 16'($urandom);
                vic_req[0] = 1'b1;
            end
            if (!pc && !pv) begin
                pc = 1'b1;
                cpu_we[0] = 1'b0; cpu_bank[0] = 7'($urandom); cpu_addr[0] = 16'($urandom);
                cpu_req[0] = 1'b1;
            end
            win_vic = (pc && pv) ? (last == CH_CPU) : pv;
            nxt_rd[0] = 8'($urandom);
            bdur[0]   = int'($urandom_range(3));
            wait_ce(0);
            check_grant(0, win_vic, cpu_we[0], win_vic ? vic_bank[0] : cpu_bank[0],
                        win_vic ? vic_addr[0] : cpu_addr[0], cpu_wdata[0]);
            wait_ack(0, win_vic, nxt_rd[0], win_vic || !cpu_we[0]);
            last = win_vic ? CH_VIC : CH_CPU;
            @(posedge clk); #1;
            if (win_vic) begin
                vic_req[0] = 1'b0; pv = 1'b0;
            end else begin
                cpu_req[0] = 1'b0; pc = 1'b0;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
